// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal shift register with frame counting and frame-latched parallel output
//
// Purpose:
//   WIDTH-bit shift register supporting hold, shift up, shift down and
//   parallel load.  Every WIDTH shifts (in either direction, mixed freely)
//   form a frame; on the shift that completes a frame the post-shift
//   register value is captured into PDOUT and FRAME_VALID pulses for one cycle.
//
// Ports:
//   CLK          in   1      rising-edge clock
//   RST          in   1      asynchronous active-low reset
//   EN           in   1      clock enable (all registered state holds when low)
//   CLR          in   1      synchronous clear, takes priority over EN
//   MODE         in   2      00 hold, 01 shift up, 10 shift down, 11 parallel load
//   SIN_LO       in   1      serial input into bit 0 on shift up
//   SIN_HI       in   1      serial input into bit WIDTH-1 on shift down
//   PIN          in   WIDTH  parallel load data
//   Q            out  WIDTH  live register contents
//   SOUT_HI      out  1      Q[WIDTH-1]
//   SOUT_LO      out  1      Q[0]
//   PDOUT        out  WIDTH  copy of Q captured at each frame completion
//   FRAME_VALID  out  1      one-cycle pulse on frame completion
//   BIT_CNT      out  CW     shifts taken in the current frame

module shift_reg_univ #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             CLR,
    input  logic [1:0]       MODE,
    input  logic             SIN_LO,
    input  logic             SIN_HI,
    input  logic [WIDTH-1:0] PIN,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT_HI,
    output logic             SOUT_LO,
    output logic [WIDTH-1:0] PDOUT,
    output logic             FRAME_VALID,
    output logic [CW-1:0]    BIT_CNT
);

    localparam logic [1:0]    MODE_HOLD = 2'b00;
    localparam logic [1:0]    MODE_UP   = 2'b01;
    localparam logic [1:0]    MODE_DOWN = 2'b10;
    localparam logic [1:0]    MODE_LOAD = 2'b11;
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_pdout;
    logic             r_frame_valid;
    logic [CW-1:0]    r_bit_cnt;

    logic [WIDTH-1:0] w_shift_up;
    logic [WIDTH-1:0] w_shift_down;
    logic [WIDTH-1:0] w_shifted;
    logic             w_frame_done;

    assign w_shift_up   = {r_q[WIDTH-2:0], SIN_LO};
    assign w_shift_down = {SIN_HI, r_q[WIDTH-1:1]};

    // Only meaningful when MODE is a shift; bit 0 picks the direction.
    assign w_shifted    = MODE[0] ? w_shift_up : w_shift_down;

    // The shift taken at count WIDTH-1 is the last bit of the frame.
    assign w_frame_done = (r_bit_cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_q           <= RST_VAL;
            r_pdout       <= '0;
            r_bit_cnt     <= '0;
            r_frame_valid <= 1'b0;
        end else if (CLR) begin
            r_q           <= RST_VAL;
            r_pdout       <= '0;
            r_bit_cnt     <= '0;
            r_frame_valid <= 1'b0;
        end else if (!EN) begin
            // MODE is not looked at here, so X/Z on it is harmless while disabled.
            r_frame_valid <= 1'b0;
        end else begin
            case (MODE)
                MODE_UP, MODE_DOWN: begin
                    r_q <= w_shifted;
                    if (w_frame_done) begin
                        // Q and PDOUT take the same post-shift value on this edge.
                        r_bit_cnt     <= '0;
                        r_pdout       <= w_shifted;
                        r_frame_valid <= 1'b1;
                    end else begin
                        r_bit_cnt     <= r_bit_cnt + CW'(1);
                        r_frame_valid <= 1'b0;
                    end
                end
                MODE_LOAD: begin
                    // A load restarts framing but keeps the last completed frame.
                    r_q           <= PIN;
                    r_bit_cnt     <= '0;
                    r_frame_valid <= 1'b0;
                end
                MODE_HOLD: begin
                    r_frame_valid <= 1'b0;
                end
                default: begin
                    r_frame_valid <= 1'b0;
                end
            endcase
        end
    end

    assign Q           = r_q;
    assign SOUT_HI     = r_q[WIDTH-1];
    assign SOUT_LO     = r_q[0];
    assign PDOUT       = r_pdout;
    assign FRAME_VALID = r_frame_valid;
    assign BIT_CNT     = r_bit_cnt;

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb/tb_shift_reg_univ.sv - directed self-checking bench for shift_reg_univ (WIDTH=4, RST_VAL=0)

module tb_shift_reg_univ;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic       sin_lo;
    logic       sin_hi;
    logic [3:0] pin;
    logic [3:0] q;
    logic       sout_hi;
    logic       sout_lo;
    logic [3:0] pdout;
    logic       frame_valid;
    logic [2:0] bit_cnt;

    int total = 0;
    int bad   = 0;

    shift_reg_univ #(
        .WIDTH   (4),
        .RST_VAL (4'b0000)
    ) dut (
        .CLK         (clk),
        .RST         (rst_n),
        .EN          (en),
        .CLR         (clr),
        .MODE        (mode),
        .SIN_LO      (sin_lo),
        .SIN_HI      (sin_hi),
        .PIN         (pin),
        .Q           (q),
        .SOUT_HI     (sout_hi),
        .SOUT_LO     (sout_lo),
        .PDOUT       (pdout),
        .FRAME_VALID (frame_valid),
        .BIT_CNT     (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] eq, input logic [2:0] ecnt,
                             input logic [3:0] epd, input logic efv);
        chk({tag, ".q"},   {28'd0, q},           {28'd0, eq});
        chk({tag, ".cnt"}, {29'd0, bit_cnt},     {29'd0, ecnt});
        chk({tag, ".pd"},  {28'd0, pdout},       {28'd0, epd});
        chk({tag, ".fv"},  {31'd0, frame_valid}, {31'd0, efv});
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        clr    = 1'b0;
        mode   = 2'b00;
        sin_lo = 1'b0;
        sin_hi = 1'b0;
        pin    = 4'h0;

        #3;
        chk_state("reset", 4'b0000, 3'd0, 4'b0000, 1'b0);
        #9;
        rst_n = 1'b1;
        tick();
        chk_state("post_reset_idle", 4'b0000, 3'd0, 4'b0000, 1'b0);

        // Shift up 1,0,1,1
        en = 1'b1; mode = 2'b01;
        sin_lo = 1'b1; tick(); chk_state("up1", 4'b0001, 3'd1, 4'b0000, 1'b0);
        sin_lo = 1'b0; tick(); chk_state("up2", 4'b0010, 3'd2, 4'b0000, 1'b0);
        sin_lo = 1'b1; tick(); chk_state("up3", 4'b0101, 3'd3, 4'b0000, 1'b0);
        sin_lo = 1'b1; tick(); chk_state("up4", 4'b1011, 3'd0, 4'b1011, 1'b1);
        chk("up4.sout_hi", {31'd0, sout_hi}, 32'd1);
        mode = 2'b00;  tick(); chk_state("up_hold", 4'b1011, 3'd0, 4'b1011, 1'b0);

        // Shift down 1,1,0,0
        mode = 2'b10;
        sin_hi = 1'b1; tick(); chk_state("dn1", 4'b1101, 3'd1, 4'b1011, 1'b0);
        sin_hi = 1'b1; tick(); chk_state("dn2", 4'b1110, 3'd2, 4'b1011, 1'b0);
        sin_hi = 1'b0; tick(); chk_state("dn3", 4'b0111, 3'd3, 4'b1011, 1'b0);
        sin_hi = 1'b0; tick(); chk_state("dn4", 4'b0011, 3'd0, 4'b0011, 1'b1);
        chk("dn4.sout_hi", {31'd0, sout_hi}, 32'd0);
        chk("dn4.sout_lo", {31'd0, sout_lo}, 32'd1);
        mode = 2'b00;  tick(); chk_state("dn_hold", 4'b0011, 3'd0, 4'b0011, 1'b0);

        // Load A then two shift-downs with SIN_HI=0
        mode = 2'b11; pin = 4'hA; tick();
        chk_state("load", 4'hA, 3'd0, 4'b0011, 1'b0);
        chk("load.sout_lo", {31'd0, sout_lo}, 32'd0);
        mode = 2'b10; sin_hi = 1'b0; tick();
        chk("ld_dn1.sout_lo", {31'd0, sout_lo}, 32'd1);
        chk_state("ld_dn1", 4'h5, 3'd1, 4'b0011, 1'b0);
        tick();
        chk_state("ld_dn2", 4'h2, 3'd2, 4'b0011, 1'b0);

        // Enable gap mid-frame
        mode = 2'b11; pin = 4'h0; tick();
        chk_state("gap_load", 4'h0, 3'd0, 4'b0011, 1'b0);
        mode = 2'b01; sin_lo = 1'b1;
        tick(); chk_state("gap_s1", 4'b0001, 3'd1, 4'b0011, 1'b0);
        tick(); chk_state("gap_s2", 4'b0011, 3'd2, 4'b0011, 1'b0);
        en = 1'b0;
        tick(); chk_state("gap_off1", 4'b0011, 3'd2, 4'b0011, 1'b0);
        mode = 2'bxx;
        tick(); chk_state("gap_off2", 4'b0011, 3'd2, 4'b0011, 1'b0);
        tick(); chk_state("gap_off3", 4'b0011, 3'd2, 4'b0011, 1'b0);
        en = 1'b1; mode = 2'b01;
        tick(); chk_state("gap_s3", 4'b0111, 3'd3, 4'b0011, 1'b0);
        tick(); chk_state("gap_s4", 4'b1111, 3'd0, 4'b1111, 1'b1);

        // Asynchronous reset mid-frame
        sin_lo = 1'b0;
        tick(); chk_state("rst_s1", 4'b1110, 3'd1, 4'b1111, 1'b0);
        tick(); chk_state("rst_s2", 4'b1100, 3'd2, 4'b1111, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_state("rst_async", 4'b0000, 3'd0, 4'b0000, 1'b0);
        #1 rst_n = 1'b1;
        sin_lo = 1'b1;
        tick(); chk_state("rst_p1", 4'b0001, 3'd1, 4'b0000, 1'b0);
        tick(); chk_state("rst_p2", 4'b0011, 3'd2, 4'b0000, 1'b0);
        tick(); chk_state("rst_p3", 4'b0111, 3'd3, 4'b0000, 1'b0);
        tick(); chk_state("rst_p4", 4'b1111, 3'd0, 4'b1111, 1'b1);

        // Clear with EN low at BIT_CNT=3
        sin_lo = 1'b0;
        tick(); chk_state("clr_s1", 4'b1110, 3'd1, 4'b1111, 1'b0);
        tick(); chk_state("clr_s2", 4'b1100, 3'd2, 4'b1111, 1'b0);
        tick(); chk_state("clr_s3", 4'b1000, 3'd3, 4'b1111, 1'b0);
        en = 1'b0; clr = 1'b1; mode = 2'bxx;
        tick(); chk_state("clr", 4'b0000, 3'd0, 4'b0000, 1'b0);
        clr = 1'b0; en = 1'b1; mode = 2'b01; sin_lo = 1'b1;
        tick(); chk_state("clr_after", 4'b0001, 3'd1, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
